// File: rtl/div_nr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_nr_pkg
//  Purpose  : Shared state type, width default and control-word bit indices
//             for the non-restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
package div_nr_pkg;

    localparam int W_DEF = 8;

    localparam int C_LDA  = 0;
    localparam int C_LDQ  = 1;
    localparam int C_LDM  = 2;
    localparam int C_ITER = 3;
    localparam int C_CORR = 4;
    localparam int C_LAST = 5;
    localparam int C_OUTR = 6;
    localparam int C_OUTQ = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_Q = 3'd2,
        S_LOAD_M = 3'd3,
        S_ITER   = 3'd4,
        S_CORR   = 3'd5,
        S_OUT_R  = 3'd6,
        S_OUT_Q  = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_nr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : div_nr_ctrl
//  Purpose  : Sequencer for the non-restoring divider: state, iteration count
//             and the per-state control word. Optional DIV_NR_DIVZERO_EN.
//  Revision : 1.0  initial release
// ============================================================================
module div_nr_ctrl
    import div_nr_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
`ifdef DIV_NR_DIVZERO_EN
    input  logic       i_m_zero,
    output logic       o_dz,
`endif
    output logic [7:0] o_c
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] c_cnt_last = CW'(W - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
`ifdef DIV_NR_DIVZERO_EN
    logic          r_dz;
    assign o_dz = r_dz;
`endif

    // rst_n is an active-high synchronous reset despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
`ifdef DIV_NR_DIVZERO_EN
            r_dz    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE:   if (i_enable) r_state <= S_LOAD_A;
                S_LOAD_A: r_state <= S_LOAD_Q;
                S_LOAD_Q: r_state <= S_LOAD_M;
                S_LOAD_M: begin
                    r_cnt <= '0;
`ifdef DIV_NR_DIVZERO_EN
                    r_dz    <= i_m_zero;
                    r_state <= i_m_zero ? S_OUT_R : S_ITER;
`else
                    r_state <= S_ITER;
`endif
                end
                S_ITER: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) r_state <= S_CORR;
                end
                S_CORR:   r_state <= S_OUT_R;
                S_OUT_R:  r_state <= S_OUT_Q;
                S_OUT_Q: begin
                    r_state <= S_IDLE;
`ifdef DIV_NR_DIVZERO_EN
                    r_dz    <= 1'b0;
`endif
                end
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_c = '0;
        case (r_state)
            S_LOAD_A: o_c[C_LDA]  = 1'b1;
            S_LOAD_Q: o_c[C_LDQ]  = 1'b1;
            S_LOAD_M: o_c[C_LDM]  = 1'b1;
            S_ITER: begin
                o_c[C_ITER] = 1'b1;
                o_c[C_LAST] = (r_cnt == c_cnt_last);
            end
            S_CORR:   o_c[C_CORR] = 1'b1;
            S_OUT_R:  o_c[C_OUTR] = 1'b1;
            S_OUT_Q:  o_c[C_OUTQ] = 1'b1;
            default:  o_c = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/div_non_restoring.sv
`default_nettype none
// ============================================================================
//  Module   : div_non_restoring
//  Purpose  : Sequential non-restoring unsigned divider {A,Q}/M with serial
//             operand load and serial result readout. Optional DIV_NR_DIVZERO_EN.
//  Revision : 1.0  initial release
// ============================================================================
module div_non_restoring
    import div_nr_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [W-1:0] inbus,
`ifdef DIV_NR_DIVZERO_EN
    output logic         div_err,
`endif
    output logic         done,
    output logic [W-1:0] outbus
);

    logic [7:0]   w_c;
    logic [W:0]   r_a;
    logic [W-1:0] r_q;
    logic [W-1:0] r_m;
    logic [W:0]   w_a_sh;
    logic [W:0]   w_m_ext;
    logic [W:0]   w_a_iter;
    logic [W:0]   w_a_corr;
`ifdef DIV_NR_DIVZERO_EN
    logic         w_dz;
`endif

    div_nr_ctrl #(.W(W)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_enable (enable),
`ifdef DIV_NR_DIVZERO_EN
        .i_m_zero (inbus == '0),
        .o_dz     (w_dz),
`endif
        .o_c      (w_c)
    );

    assign w_m_ext  = {1'b0, r_m};
    assign w_a_sh   = {r_a[W-1:0], r_q[W-1]};
    // sign of the stored partial remainder picks subtract or add-back
    assign w_a_iter = r_a[W] ? (w_a_sh + w_m_ext) : (w_a_sh - w_m_ext);
    assign w_a_corr = r_a + w_m_ext;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_a <= '0;
            r_q <= '0;
            r_m <= '0;
        end else begin
            if (w_c[C_LDA]) r_a <= {1'b0, inbus};
            if (w_c[C_LDQ]) r_q <= inbus;
            if (w_c[C_LDM]) r_m <= inbus;
            if (w_c[C_ITER]) begin
                r_a <= w_a_iter;
                r_q <= {r_q[W-2:0], ~w_a_iter[W]};
            end
            if (w_c[C_CORR] && r_a[W]) r_a <= w_a_corr;
        end
    end

    always_comb begin
        done   = w_c[C_OUTR] | w_c[C_OUTQ];
        outbus = '0;
        if (w_c[C_OUTR])      outbus = r_a[W-1:0];
        else if (w_c[C_OUTQ]) outbus = r_q;
`ifdef DIV_NR_DIVZERO_EN
        div_err = w_dz & done;
        if (w_dz) outbus = '0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_div_non_restoring.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_non_restoring
//  Purpose  : Scoreboard bench for div_non_restoring against an arithmetic
//             reference ({A,Q} / M). Optional DIV_NR_DIVZERO_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_non_restoring;
    import div_nr_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] inbus = 8'd0;
    logic       done;
    logic [7:0] outbus;
`ifdef DIV_NR_DIVZERO_EN
    logic       div_err;
`endif

    div_non_restoring #(.W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .inbus   (inbus),
`ifdef DIV_NR_DIVZERO_EN
        .div_err (div_err),
`endif
        .done    (done),
        .outbus  (outbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rem;
        logic [7:0] quot;
        bit         err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   t_prev = 0;
    int   t_last = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_div(input logic [7:0] a, q, m);
        exp_t e;
        int   dividend;
        dividend = int'({a, q});
        e.err = 1'b0;
        if (m == 8'd0) begin
`ifdef DIV_NR_DIVZERO_EN
            e.rem = 8'd0; e.quot = 8'd0; e.err = 1'b1;
`else
            // zero divisor with A=0: every quotient bit is 1 and the dividend ends up in A
            e.rem = q; e.quot = 8'hff;
`endif
        end else begin
            e.rem  = 8'(dividend % int'(m));
            e.quot = 8'(dividend / int'(m));
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard as result words appear.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else if (dut.w_c[C_OUTR]) begin
                t_prev = t_last;
                t_last = cyc;
                chk("remainder", int'(outbus), int'(sb[0].rem));
`ifdef DIV_NR_DIVZERO_EN
                chk("div_err_r", int'(div_err), int'(sb[0].err));
`endif
            end else if (dut.w_c[C_OUTQ]) begin
                chk("quotient", int'(outbus), int'(sb[0].quot));
`ifdef DIV_NR_DIVZERO_EN
                chk("div_err_q", int'(div_err), int'(sb[0].err));
`endif
                void'(sb.pop_front());
            end else begin
                chk("done_without_out_phase", 1, 0);
            end
        end else if (outbus != 8'd0) begin
            chk("outbus_idle_zero", int'(outbus), 0);
        end
    end

    // Caller sits just after a clock edge with the divider idle.
    task automatic run_div(input logic [7:0] a, q, m, input bit poke);
        int lat;
        int k;
        int exp_lat;
        exp_t e;
        e = ref_div(a, q, m);
        exp_lat = 12;
`ifdef DIV_NR_DIVZERO_EN
        if (m == 8'd0) exp_lat = 3;
`endif
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        inbus  = a;
        sb.push_back(e);
        @(posedge clk); #1; inbus = q;
        @(posedge clk); #1; inbus = m;
        @(posedge clk); #1; inbus = 8'd0;
        lat = 3;
        while (!done && lat < 40) begin
            enable = (poke && lat == 6);
            @(posedge clk); #1;
            lat++;
        end
        enable = 1'b0;
        chk("latency", lat, exp_lat);
        k = 0;
        while (done && k < 6) begin
            @(posedge clk); #1;
            k++;
        end
        chk("done_width", k, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, q, m;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", int'(done), 0);
        chk("rst_outbus", int'(outbus), 0);
        chk("rst_c", int'(dut.w_c), 0);
        chk("rst_state", int'(dut.u_ctrl.r_state), int'(S_IDLE));
        rst_n = 1'b0;
        @(posedge clk); #1;

        run_div(8'd0, 8'd127, 8'd25, 1'b0);
        run_div(8'd1, 8'd0,   8'd25, 1'b0);
        run_div(8'd0, 8'd255, 8'd1,  1'b0);
        run_div(8'd0, 8'd0,   8'd7,  1'b0);
        run_div(8'd24, 8'd255, 8'd25, 1'b0);
        run_div(8'd254, 8'd255, 8'd255, 1'b0);
        run_div(8'd0, 8'd173, 8'd0,  1'b0);

        // abort mid-iteration: reset lands in the 4th ITER cycle
        enable = 1'b1;
        @(posedge clk); #1; enable = 1'b0; inbus = 8'd3;
        @(posedge clk); #1; inbus = 8'd99;
        @(posedge clk); #1; inbus = 8'd50;
        @(posedge clk); #1; inbus = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", int'(dut.u_ctrl.r_state), int'(S_IDLE));
        chk("abort_done", int'(done), 0);
        chk("abort_outbus", int'(outbus), 0);
        chk("abort_c", int'(dut.w_c), 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        run_div(8'd0, 8'd200, 8'd200, 1'b0);

        // start request during ITER must not disturb the run or restart it
        run_div(8'd10, 8'd77, 8'd33, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("no_restart_state", int'(dut.u_ctrl.r_state), int'(S_IDLE));

        // back-to-back: second remainder follows the first by 15 cycles
        run_div(8'd5, 8'd9, 8'd12, 1'b0);
        run_div(8'd0, 8'd250, 8'd3, 1'b0);
        chk("back_to_back_gap", t_last - t_prev, 15);

        for (int i = 0; i < 25; i++) begin
            m = 8'($urandom_range(1, 255));
            a = 8'($urandom_range(0, int'(m) - 1));
            q = 8'($urandom);
            run_div(a, q, m, 1'b0);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
